dp_reset_ce_sequencer: RTL and testbench
========================================

// Module: dp_reset_ce_sequencer
// PURPOSE
//  Power-up/run controller for a downstream datapath that has a synchronous active-high reset and a clock enable.
//  On a start request it holds the datapath in reset for a fixed number of cycles, then releases reset.
//  It waits for the datapath's ready, then enables ce; on stop it drains and returns the datapath to reset.
//  Sits between the system control logic and the datapath's rst/ce pins, in the same clock domain.
// PARAMETERS
//  RST_HOLD  2   cycles dut_rst stays high after start is accepted (1..2^CNT_W-1)
//  CE_DELAY  1   cycles between dp_ready seen and dut_ce rising (0 = next cycle)
//  DRAIN     1   cycles after stop, with dut_ce=0, before dut_rst re-asserts (1..2^CNT_W-1)
//  TIMEOUT   8   max cycles in WAIT_RDY without dp_ready before error (1..2^CNT_W-1)
//  CNT_W     4   width of the shared down-counter
// PORTS
//  clk       in   1  clock, all logic on posedge
//  rst       in   1  asynchronous, active-low block reset
//  start     in   1  level request to bring the datapath up; sampled in IDLE only
//  stop      in   1  level request to shut the datapath down; honoured in any non-IDLE, non-ERROR state
//  dp_ready  in   1  datapath reports it is out of reset and idle
//  clr_err   in   1  clears ERROR, returns to IDLE
//  dut_rst   out  1  reset to datapath, active-high, registered
//  dut_ce    out  1  clock enable to datapath, registered
//  running   out  1  high while in RUN
//  up_done   out  1  one-cycle pulse on the first cycle of RUN
//  err       out  1  sticky timeout flag, high while in ERROR
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, cnt=0, dut_rst=1, dut_ce=0, running=0, up_done=0, err=0.
//  All outputs are registered and are a function of the current state; there are no combinational input->output paths.
//  States/transitions (edge = posedge clk):
//   IDLE:     dut_rst=1, dut_ce=0. start=1 & stop=0 -> HOLD, cnt<=RST_HOLD-1. start & stop both high -> stay IDLE.
//   HOLD:     dut_rst=1. cnt==0 -> WAIT_RDY, cnt<=TIMEOUT-1; else cnt--.
//             => dut_rst falls exactly RST_HOLD cycles after the edge that sampled start.
//   WAIT_RDY: dut_rst=0, dut_ce=0.
//             dp_ready=1 -> CE_DLY with cnt<=CE_DELAY-1, or straight to RUN if CE_DELAY==0.
//             Otherwise cnt==0 -> ERROR, else cnt--.
//             dp_ready=1 on the same edge as cnt==0: dp_ready wins.
//   CE_DLY:   dut_rst=0, dut_ce=0. cnt==0 -> RUN; else cnt--. dp_ready is not re-checked.
//   RUN:      dut_rst=0, dut_ce=1, running=1. up_done=1 on the entry cycle only. start is ignored.
//             stop=1 -> DRAIN, cnt<=DRAIN-1.
//   DRAIN:    dut_rst=0, dut_ce=0. cnt==0 -> IDLE (dut_rst=1 from the next cycle); else cnt--. start is ignored.
//   ERROR:    dut_rst=1, dut_ce=0, err=1. clr_err=1 -> IDLE. start and stop are ignored.
//  stop in HOLD/WAIT_RDY/CE_DLY -> IDLE on that edge (abort; no DRAIN, because ce was never high).
//  stop has priority over every other transition condition except the ERROR exit.
//  Invariant: dut_rst and dut_ce are never both 1. dut_ce=1 only in RUN.
//  Counter: unsigned CNT_W-bit down-counter. Loads are truncated to CNT_W bits, so parameters must fit in CNT_W.
//   Loads and decrements never wrap below 0.
//  Assertion of rst mid-operation: immediate return to reset values (dut_rst=1, dut_ce=0), regardless of state.
// TESTING
//  T1 nominal: defaults, start=1 one cycle at edge 3, dp_ready=1 from edge 4
//     -> dut_rst falls at edge 5; dut_ce rises at edge 7; up_done pulses at edge 7.
//  T2 reset window: assert in the bench that after start is accepted, !dut_rst is true at edge +2 (within [2:3])
//     and dut_rst & dut_ce is never true.
//  T3 timeout: dp_ready held 0 -> ERROR and err=1 exactly 8 cycles after dut_rst falls, with dut_rst=1.
//     clr_err=1 -> IDLE next edge, err=0.
//  T4 stop in RUN: stop=1 for 1 cycle in RUN -> dut_ce=0 next edge; dut_rst=1 one edge later (DRAIN=1); running=0.
//  T5 abort: stop=1 while in HOLD -> IDLE next edge with dut_rst=1; no up_done pulse.
//     start&stop together in IDLE -> no state change.
//  T6 async reset mid-RUN: rst=0 between edges -> dut_ce=0 and dut_rst=1 immediately.
//     After release, start works as in T1.

Source files
------------

// File: rtl/dp_reset_ce_sequencer.sv
// ============================================================================
// Module  : dp_reset_ce_sequencer
// Brief   : Brings a downstream datapath out of reset, enables ce once it is
//           ready, and drains it back into reset on stop.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dp_reset_ce_sequencer #(
    parameter int RST_HOLD = 2,
    parameter int CE_DELAY = 1,
    parameter int DRAIN    = 1,
    parameter int TIMEOUT  = 8,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic stop,
    input  logic dp_ready,
    input  logic clr_err,
    output logic dut_rst,
    output logic dut_ce,
    output logic running,
    output logic up_done,
    output logic err
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_HOLD  = 3'd1;
    localparam logic [2:0] c_ST_WAIT  = 3'd2;
    localparam logic [2:0] c_ST_CEDLY = 3'd3;
    localparam logic [2:0] c_ST_RUN   = 3'd4;
    localparam logic [2:0] c_ST_DRAIN = 3'd5;
    localparam logic [2:0] c_ST_ERROR = 3'd6;

    // Counter loads saturate at zero so a zero parameter never wraps the counter
    localparam logic [CNT_W-1:0] c_LD_HOLD  = CNT_W'((RST_HOLD > 0) ? RST_HOLD - 1 : 0);
    localparam logic [CNT_W-1:0] c_LD_CE    = CNT_W'((CE_DELAY > 0) ? CE_DELAY - 1 : 0);
    localparam logic [CNT_W-1:0] c_LD_DRAIN = CNT_W'((DRAIN > 0) ? DRAIN - 1 : 0);
    localparam logic [CNT_W-1:0] c_LD_TMO   = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic             c_CE_SKIP  = (CE_DELAY == 0);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;

    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_dec;
    logic             w_cnt_zero;
    logic             w_rst_nxt;
    logic             w_ce_nxt;
    logic             w_run_nxt;
    logic             w_up_nxt;
    logic             w_err_nxt;

    assign w_cnt_zero = (r_cnt == '0);
    assign w_cnt_dec  = w_cnt_zero ? r_cnt : r_cnt - 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            dut_rst <= 1'b1;
            dut_ce  <= 1'b0;
            running <= 1'b0;
            up_done <= 1'b0;
            err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            dut_rst <= w_rst_nxt;
            dut_ce  <= w_ce_nxt;
            running <= w_run_nxt;
            up_done <= w_up_nxt;
            err     <= w_err_nxt;
        end
    end

    // stop beats every other exit condition; ERROR only leaves on clr_err
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_ST_IDLE: begin
                if (start && !stop) begin
                    w_state_nxt = c_ST_HOLD;
                    w_cnt_nxt   = c_LD_HOLD;
                end
            end
            c_ST_HOLD: begin
                if (stop) begin
                    w_state_nxt = c_ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_cnt_zero) begin
                    w_state_nxt = c_ST_WAIT;
                    w_cnt_nxt   = c_LD_TMO;
                end else begin
                    w_cnt_nxt   = w_cnt_dec;
                end
            end
            c_ST_WAIT: begin
                if (stop) begin
                    w_state_nxt = c_ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (dp_ready) begin
                    w_state_nxt = c_CE_SKIP ? c_ST_RUN : c_ST_CEDLY;
                    w_cnt_nxt   = c_LD_CE;
                end else if (w_cnt_zero) begin
                    w_state_nxt = c_ST_ERROR;
                end else begin
                    w_cnt_nxt   = w_cnt_dec;
                end
            end
            c_ST_CEDLY: begin
                if (stop) begin
                    w_state_nxt = c_ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_cnt_zero) begin
                    w_state_nxt = c_ST_RUN;
                end else begin
                    w_cnt_nxt   = w_cnt_dec;
                end
            end
            c_ST_RUN: begin
                if (stop) begin
                    w_state_nxt = c_ST_DRAIN;
                    w_cnt_nxt   = c_LD_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (w_cnt_zero) begin
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_cnt_nxt   = w_cnt_dec;
                end
            end
            c_ST_ERROR: begin
                if (clr_err) begin
                    w_state_nxt = c_ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registers track the state
    always_comb begin
        w_rst_nxt = (w_state_nxt == c_ST_IDLE) || (w_state_nxt == c_ST_HOLD) ||
                    (w_state_nxt == c_ST_ERROR);
        w_ce_nxt  = (w_state_nxt == c_ST_RUN);
        w_run_nxt = (w_state_nxt == c_ST_RUN);
        w_up_nxt  = (w_state_nxt == c_ST_RUN) && (r_state != c_ST_RUN);
        w_err_nxt = (w_state_nxt == c_ST_ERROR);
    end

endmodule

`default_nettype wire

// File: tb/tb_dp_reset_ce_sequencer.sv
// ============================================================================
// Module  : tb_dp_reset_ce_sequencer
// Brief   : Directed stimulus with an output-change scoreboard for the sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dp_reset_ce_sequencer;

    logic clk;
    logic rst;
    logic start;
    logic stop;
    logic dp_ready;
    logic clr_err;
    logic dut_rst;
    logic dut_ce;
    logic running;
    logic up_done;
    logic err;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;
    bit mon_en   = 1'b0;

    typedef struct {
        int         cyc;
        logic [4:0] vec;
    } exp_t;

    exp_t q[$];

    // {dut_rst, dut_ce, running, up_done, err}
    localparam logic [4:0] V_RST  = 5'b10000;
    localparam logic [4:0] V_OFF  = 5'b00000;
    localparam logic [4:0] V_UP   = 5'b01110;
    localparam logic [4:0] V_RUN  = 5'b01100;
    localparam logic [4:0] V_ERR  = 5'b10001;

    dp_reset_ce_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .dp_ready (dp_ready),
        .clr_err  (clr_err),
        .dut_rst  (dut_rst),
        .dut_ce   (dut_ce),
        .running  (running),
        .up_done  (up_done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_n = edge_n + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic push(input int c, input logic [4:0] v);
        exp_t e;
        e.cyc = c;
        e.vec = v;
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every change of the output vector must match the next expectation
    logic [4:0] prev_vec;
    always @(negedge clk) begin
        logic [4:0] vec;
        exp_t e;
        if (mon_en) begin
            vec = {dut_rst, dut_ce, running, up_done, err};
            chk("rst_ce_exclusive", {31'd0, dut_rst & dut_ce}, 32'd0);
            if (vec !== prev_vec) begin
                if (q.size() == 0) begin
                    chk("unexpected_change", {27'd0, vec}, {27'd0, prev_vec});
                end else begin
                    e = q.pop_front();
                    chk("out_vec", {27'd0, vec}, {27'd0, e.vec});
                    chk("out_edge", edge_n, e.cyc);
                end
                prev_vec = vec;
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        int m;
        rst      = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        dp_ready = 1'b0;
        clr_err  = 1'b0;
        #1 rst = 1'b0;
        #3;
        chk("reset_vec", {27'd0, dut_rst, dut_ce, running, up_done, err}, {27'd0, V_RST});
        tick(2);
        rst      = 1'b1;
        prev_vec = {dut_rst, dut_ce, running, up_done, err};
        mon_en   = 1'b1;

        // T1 nominal bring-up: start sampled at edge 3
        s = edge_n + 1;
        start = 1'b1;
        push(s + 2, V_OFF);
        push(s + 4, V_UP);
        push(s + 5, V_RUN);
        tick(1);
        start    = 1'b0;
        dp_ready = 1'b1;
        tick(5);

        // T4 stop in RUN, one-cycle drain
        m = edge_n;
        stop = 1'b1;
        push(m + 1, V_OFF);
        push(m + 2, V_RST);
        tick(1);
        stop     = 1'b0;
        dp_ready = 1'b0;
        tick(3);

        // T3 timeout into ERROR, start/stop ignored there, clr_err back to IDLE
        s = edge_n + 1;
        start = 1'b1;
        push(s + 2, V_OFF);
        push(s + 10, V_ERR);
        tick(1);
        start = 1'b0;
        tick(10);
        start = 1'b1;
        stop  = 1'b1;
        tick(2);
        start   = 1'b0;
        stop    = 1'b0;
        clr_err = 1'b1;
        push(edge_n + 1, V_RST);
        tick(1);
        clr_err = 1'b0;
        tick(2);

        // dp_ready arriving on the same edge the timeout counter hits zero
        s = edge_n + 1;
        start = 1'b1;
        push(s + 2, V_OFF);
        push(s + 11, V_UP);
        push(s + 12, V_RUN);
        tick(1);
        start = 1'b0;
        tick(9);
        dp_ready = 1'b1;
        tick(3);
        m = edge_n;
        stop     = 1'b1;
        dp_ready = 1'b0;
        push(m + 1, V_OFF);
        push(m + 2, V_RST);
        tick(1);
        stop = 1'b0;
        tick(3);

        // T5 abort in HOLD: no output change at all afterwards
        start = 1'b1;
        tick(1);
        start = 1'b0;
        stop  = 1'b1;
        tick(1);
        stop = 1'b0;
        tick(4);
        start = 1'b1;
        stop  = 1'b1;
        tick(4);
        start = 1'b0;
        stop  = 1'b0;
        tick(1);

        // Abort in WAIT_RDY returns straight to reset
        s = edge_n + 1;
        start = 1'b1;
        push(s + 2, V_OFF);
        push(s + 3, V_RST);
        tick(1);
        start = 1'b0;
        tick(2);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        tick(3);

        // T6 asynchronous reset while running
        s = edge_n + 1;
        start = 1'b1;
        push(s + 2, V_OFF);
        push(s + 4, V_UP);
        push(s + 5, V_RUN);
        tick(1);
        start    = 1'b0;
        dp_ready = 1'b1;
        tick(6);
        #2;
        rst = 1'b0;
        push(edge_n + 1, V_RST);
        #1;
        chk("async_ce",  {31'd0, dut_ce},  32'd0);
        chk("async_rst", {31'd0, dut_rst}, 32'd1);
        chk("async_run", {31'd0, running}, 32'd0);
        dp_ready = 1'b0;
        tick(2);
        #2 rst = 1'b1;
        tick(1);

        // Bring-up after reset release behaves as T1
        s = edge_n + 1;
        start = 1'b1;
        push(s + 2, V_OFF);
        push(s + 4, V_UP);
        push(s + 5, V_RUN);
        tick(1);
        start    = 1'b0;
        dp_ready = 1'b1;
        tick(6);

        chk("queue_empty", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
